// File: rtl/adder_arbiter.sv
// adder_arbiter: one shared width-bit adder serving four requesters.
// Round-robin arbitration picks at most one valid request per cycle. The
// winner's a + b + cin goes into a single-entry result register that has
// valid/ready backpressure. The result register may be refilled in the same
// cycle it drains, so a steady stream runs at one result per cycle.
module adder_arbiter #(
   parameter int width = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [3:0]             req_valid,
   output logic [3:0]             req_ready,
   input  logic [4*width-1:0]     req_a,
   input  logic [4*width-1:0]     req_b,
   input  logic [3:0]             req_cin,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [width-1:0]       rsp_sum,
   output logic                   rsp_cout,
   output logic [1:0]             rsp_id
);

   // Round-robin pointer: index that has highest priority this cycle.
   logic [1:0]       ptr;

   // Arbitration results.
   logic             can_accept;
   logic             found;
   logic [1:0]       grant_idx;
   logic [1:0]       scan_idx;
   logic             xfer;

   // Operands of the granted requester and the width+1 bit sum.
   logic [width-1:0] a_sel;
   logic [width-1:0] b_sel;
   logic             cin_sel;
   logic [width:0]   sum_full;

   // Unsigned add at width+1 bits; the top bit is the carry-out and the
   // low bits wrap on overflow.
   function automatic logic [width:0] add_wide(input logic [width-1:0] a,
                                               input logic [width-1:0] b,
                                               input logic             cin);
      add_wide = {1'b0, a} + {1'b0, b} + {{width{1'b0}}, cin};
   endfunction

   // Converts a 2-bit index into a 4-bit one-hot vector.
   function automatic logic [3:0] onehot4(input logic [1:0] idx);
      onehot4 = 4'b0001 << idx;
   endfunction

   // The result register can take a new value if it is empty or being
   // drained in this same cycle.
   assign can_accept = !rsp_valid || rsp_ready;

   // Scan from ptr upward (mod 4) and take the first valid requester.
   always_comb begin
      found     = 1'b0;
      grant_idx = ptr;
      scan_idx  = ptr;
      for (int k = 0; k < 4; k++) begin
         scan_idx = ptr + k[1:0];
         if (!found && req_valid[scan_idx]) begin
            found     = 1'b1;
            grant_idx = scan_idx;
         end
      end
   end

   // Grant is one-hot and suppressed while reset is held or the result
   // register cannot accept a new value.
   always_comb begin
      req_ready = 4'b0000;
      if (found && can_accept && !reset) begin
         req_ready = onehot4(grant_idx);
      end
   end

   // A transfer happens when the granted requester is valid, which is
   // guaranteed by construction of the grant but kept explicit here.
   assign xfer = |(req_valid & req_ready);

   // Operand mux feeding the single shared adder.
   always_comb begin
      a_sel    = req_a[grant_idx*width +: width];
      b_sel    = req_b[grant_idx*width +: width];
      cin_sel  = req_cin[grant_idx];
      sum_full = add_wide(a_sel, b_sel, cin_sel);
   end

   // Result register and pointer update. A transfer loads a new result and
   // rotates priority past the winner; a drain without a transfer only
   // clears valid and leaves the last payload visible.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr       <= 2'd0;
         rsp_valid <= 1'b0;
         rsp_sum   <= '0;
         rsp_cout  <= 1'b0;
         rsp_id    <= 2'd0;
      end else if (xfer) begin
         ptr       <= grant_idx + 2'd1;
         rsp_valid <= 1'b1;
         rsp_sum   <= sum_full[width-1:0];
         rsp_cout  <= sum_full[width];
         rsp_id    <= grant_idx;
      end else if (rsp_valid && rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed testbench for adder_arbiter with hand-computed expected values.
module tb_adder_arbiter;

   localparam int width = 32;

   logic                 clk;
   logic                 reset;
   logic [3:0]           req_valid;
   logic [3:0]           req_ready;
   logic [4*width-1:0]   req_a;
   logic [4*width-1:0]   req_b;
   logic [3:0]           req_cin;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [width-1:0]     rsp_sum;
   logic                 rsp_cout;
   logic [1:0]           rsp_id;

   logic [width-1:0]     a_t [4];
   logic [width-1:0]     b_t [4];

   int checks = 0;
   int errors = 0;

   adder_arbiter #(.width(width)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_cin   (req_cin),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_sum   (rsp_sum),
      .rsp_cout  (rsp_cout),
      .rsp_id    (rsp_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pack per-requester operand tables onto the flat buses.
   always_comb begin
      req_a = '0;
      req_b = '0;
      for (int i = 0; i < 4; i++) begin
         req_a[i*width +: width] = a_t[i];
         req_b[i*width +: width] = b_t[i];
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Round-robin operand table: sums are 0x11, 0x23, 0x33, 0x45.
   task automatic load_rr_ops();
      a_t[0] = 32'h10; b_t[0] = 32'h1;
      a_t[1] = 32'h20; b_t[1] = 32'h2;
      a_t[2] = 32'h30; b_t[2] = 32'h3;
      a_t[3] = 32'h40; b_t[3] = 32'h4;
      req_cin = 4'b1010;
   endtask

   logic [1:0]       rr_id  [5];
   logic [width-1:0] rr_sum [5];

   initial begin
      reset     = 1'b1;
      rsp_ready = 1'b1;
      req_valid = 4'b1111;
      load_rr_ops();

      // Reset held with all requests valid.
      repeat (2) tick();
      check("rst_req_ready", req_ready, 4'b0000);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_rsp_sum",   rsp_sum,   32'h0);
      check("rst_rsp_cout",  rsp_cout,  1'b0);
      check("rst_rsp_id",    rsp_id,    2'd0);

      // First grant after release goes to requester 0.
      reset = 1'b0;
      #1;
      check("first_grant", req_ready, 4'b0001);
      tick();
      check("first_valid", rsp_valid, 1'b1);
      check("first_id",    rsp_id,    2'd0);
      check("first_sum",   rsp_sum,   32'h11);
      req_valid = 4'b0000;
      tick();
      check("drain_valid", rsp_valid, 1'b0);
      check("drain_hold_id", rsp_id, 2'd0);

      // Single request from requester 2: 5 + 3 + 1 = 9.
      a_t[2] = 32'h5; b_t[2] = 32'h3; req_cin = 4'b0100;
      req_valid = 4'b0100;
      #1;
      check("single_grant", req_ready, 4'b0100);
      tick();
      check("single_valid", rsp_valid, 1'b1);
      check("single_sum",   rsp_sum,   32'h9);
      check("single_cout",  rsp_cout,  1'b0);
      check("single_id",    rsp_id,    2'd2);

      // Wrap-around: FFFFFFFF + 1 + 0, then FFFFFFFF + FFFFFFFF + 1 back to back.
      a_t[0] = 32'hFFFF_FFFF; b_t[0] = 32'h1;
      a_t[1] = 32'hFFFF_FFFF; b_t[1] = 32'hFFFF_FFFF;
      req_cin   = 4'b0010;
      req_valid = 4'b0001;
      tick();
      check("wrap1_sum",  rsp_sum,  32'h0);
      check("wrap1_cout", rsp_cout, 1'b1);
      check("wrap1_id",   rsp_id,   2'd0);
      req_valid = 4'b0010;
      tick();
      check("wrap2_valid", rsp_valid, 1'b1);
      check("wrap2_sum",   rsp_sum,   32'hFFFF_FFFF);
      check("wrap2_cout",  rsp_cout,  1'b1);
      check("wrap2_id",    rsp_id,    2'd1);
      req_valid = 4'b0000;
      tick();
      check("wrap_drain", rsp_valid, 1'b0);

      // Restart from reset so the pointer is back at 0.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      load_rr_ops();

      // Round-robin with all four valid: 0,1,2,3,0.
      rr_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      rr_sum = '{32'h11, 32'h23, 32'h33, 32'h45, 32'h11};
      req_valid = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("rr4_id%0d", i),  rsp_id,    rr_id[i]);
         check($sformatf("rr4_sum%0d", i), rsp_sum,   rr_sum[i]);
         check($sformatf("rr4_vld%0d", i), rsp_valid, 1'b1);
      end

      // Only requesters 1 and 3: alternate 1,3,1,3 (pointer is at 1 now).
      rr_id  = '{2'd1, 2'd3, 2'd1, 2'd3, 2'd1};
      rr_sum = '{32'h23, 32'h45, 32'h23, 32'h45, 32'h23};
      req_valid = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("rr2_id%0d", i),  rsp_id,  rr_id[i]);
         check($sformatf("rr2_sum%0d", i), rsp_sum, rr_sum[i]);
      end

      // Backpressure: result from requester 3 pending, pointer at 0.
      rsp_ready = 1'b0;
      req_valid = 4'b1111;
      #1;
      check("bp_req_ready0", req_ready, 4'b0000);
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("bp_req_ready%0d", i + 1), req_ready, 4'b0000);
         check($sformatf("bp_valid%0d", i), rsp_valid, 1'b1);
         check($sformatf("bp_id%0d", i),    rsp_id,    2'd3);
         check($sformatf("bp_sum%0d", i),   rsp_sum,   32'h45);
      end
      // Release: pointer must still be 0, and drain/refill happen together.
      rsp_ready = 1'b1;
      #1;
      check("bp_release_grant", req_ready, 4'b0001);
      tick();
      check("bp_refill_valid", rsp_valid, 1'b1);
      check("bp_refill_id",    rsp_id,    2'd0);
      check("bp_refill_sum",   rsp_sum,   32'h11);
      req_valid = 4'b0000;
      tick();
      check("bp_final_drain", rsp_valid, 1'b0);

      // Reset mid-stream with a stalled result pending.
      req_valid = 4'b0100;
      tick();
      check("mid_pending_id", rsp_id, 2'd2);
      rsp_ready = 1'b0;
      req_valid = 4'b1111;
      reset     = 1'b1;
      #1;
      check("mid_rst_ready", req_ready, 4'b0000);
      tick();
      check("mid_rst_valid", rsp_valid, 1'b0);
      check("mid_rst_sum",   rsp_sum,   32'h0);
      check("mid_rst_id",    rsp_id,    2'd0);
      reset     = 1'b0;
      rsp_ready = 1'b1;
      #1;
      check("mid_restart_grant", req_ready, 4'b0001);
      tick();
      check("mid_restart_id",  rsp_id,  2'd0);
      check("mid_restart_sum", rsp_sum, 32'h11);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Absolute time bound so the run always ends.
   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Shares one `width`-bit adder among four requesters in the processor datapath, e.g. PC increment, branch target, address generation and ALU. Each cycle, round-robin arbitration picks at most one valid request and computes `a + b + cin`. The result goes into a single-entry output register with valid/ready backpressure, so a request issued in one cycle produces its tagged result on the next cycle.

## Interface
- `width`, default 32, operand and sum width.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  4  request valid, one bit per requester i.
- `req_ready`  out  4  one-hot grant. Bit i high means requester i is accepted this cycle.
- `req_a`  in  4*width  operand A. Requester i uses slice `[i*width +: width]`.
- `req_b`  in  4*width  operand B, sliced the same way.
- `req_cin`  in  4  carry-in, one bit per requester.
- `rsp_valid`  out  1  result register holds an unconsumed result.
- `rsp_ready`  in  1  consumer accepts the result this cycle.
- `rsp_sum`  out  width  registered sum.
- `rsp_cout`  out  1  registered carry-out.
- `rsp_id`  out  2  index of the requester that owns the result.

## Operation
- Internal state:
  - round-robin pointer `ptr[1:0]`.
  - output register `{rsp_valid, rsp_id, rsp_cout, rsp_sum}`.
- `can_accept = !rsp_valid || rsp_ready`. The register may be refilled in the same cycle it drains.
- Arbitration, combinational:
  - Scan indices in the order `ptr, ptr+1, ptr+2, ptr+3` (mod 4).
  - `g` is the first index with `req_valid[g]=1`.
  - `req_ready[g] = can_accept`. All other `req_ready` bits are 0.
  - `req_ready` is all-zero when no request is valid, when `can_accept=0`, or while `reset=1`.
- Transfer for requester i means `req_valid[i] && req_ready[i]`. On a transfer to g, at the clock edge:
  - `{rsp_cout, rsp_sum} <= a_g + b_g + cin_g`, computed at width+1 bits.
  - `rsp_id <= g` and `rsp_valid <= 1`.
  - `ptr <= g+1` mod 4, so g becomes lowest priority.
- If there is no transfer but `rsp_valid && rsp_ready`: `rsp_valid <= 0`. `rsp_sum`, `rsp_cout` and `rsp_id` hold their values.
- If there is no transfer and no drain, all state holds. `ptr` changes only on a transfer.
- Requesters must hold `req_valid` and their operands stable until granted. The arbiter never drops a granted request.
- Arithmetic: `rsp_sum` is the low `width` bits of the sum and `rsp_cout` is bit `width`. Overflow wraps; there is no saturation and no signed-overflow flag.

## Timing
- Latency: request granted in cycle N gives `rsp_valid=1` with its result in cycle N+1.
- Throughput: one result per cycle while `rsp_ready=1`.
- Backpressure: while `rsp_valid=1 && rsp_ready=0`:
  - `req_ready=0`.
  - `rsp_sum`, `rsp_cout` and `rsp_id` are stable.
- Simultaneous drain and grant in one cycle: the new result replaces the old with no bubble, and `rsp_valid` stays 1.
- Fairness: with all four requests held valid and `rsp_ready=1`, grants rotate 0,1,2,3,0 (from reset). Any continuously valid requester is granted within 4 transfers.
- Reset values: `rsp_valid=0`, `rsp_sum=0`, `rsp_cout=0`, `rsp_id=0`, `ptr=0`, `req_ready=0`.
- Reset mid-operation discards any pending result and restores the reset values. Any transfer in the reset cycle is not captured.

## Test plan
- **Reset:** hold `reset=1` with all `req_valid=1`. Require `req_ready=0` and `rsp_valid=0`. After release, the first grant is requester 0.
- **Single request:** requester 2 sends a=0x00000005, b=0x00000003, cin=1. Next cycle: `rsp_valid=1`, `rsp_sum=0x00000009`, `rsp_cout=0`, `rsp_id=2`.
- **Wrap-around:** a=0xFFFFFFFF, b=0x00000001, cin=0. Require `rsp_sum=0x00000000`, `rsp_cout=1`. Also a=b=0xFFFFFFFF, cin=1, which requires `rsp_sum=0xFFFFFFFF`, `rsp_cout=1`.
- **Round-robin:** all four requesters valid, `rsp_ready=1`. Require `rsp_id` sequence 0,1,2,3,0 on consecutive cycles.
  - Repeat with only requesters 1 and 3 valid, which requires alternation 1,3,1,3.
- **Backpressure:** hold `rsp_ready=0` for 3 cycles while a result is pending and requesters are valid. Require:
  - `req_ready=0` and the output register unchanged during the stall.
  - `ptr` frozen.
  - On release, drain and refill in the same cycle, with no lost or duplicated results.
- **Reset mid-stream:** assert `reset` while `rsp_valid=1` and `rsp_ready=0`. Next cycle `rsp_valid=0`, and arbitration restarts at requester 0.
